sdram_write: RTL and testbench

Write-side SDRAM engine that drains a 16-bit source buffer into SDRAM one full row (512 words, 128 bursts of 4) at a time, for the frame store later read back for VGA. Requests the SDRAM bus from the top-level arbiter, issues ACT / WR / PALL commands in the 18-bit command format shared by all SDRAM sub-blocks, and yields to auto-refresh at burst boundaries. Bank 0, rows 0–299 (one 640x480 8-bit frame), wrapping.

---
 rtl/sdram_write.sv | 137 +++++++++++++
 tb/tb_sdram_write.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_write.sv
// SDRAM write engine: drains the source buffer one 512-word row at a time
// into bank 0, yielding to refresh only at burst boundaries.
module sdram_write #(
    parameter int ROW_MAX     = 299,
    parameter int START_LEVEL = 512
) (
    input  logic        clk,
    input  logic        rst,
    output logic        w_req,
    input  logic        w_en,
    input  logic        ref_req,
    output logic        write_ref_break_end,
    output logic        write_data_end,
    output logic [17:0] w_cmd,
    output logic [15:0] w_dq,
    output logic        w_dq_oe,
    input  logic [10:0] src_rd_count,
    output logic        src_rd_en,
    input  logic [15:0] src_rd_data
);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        WREQ   = 5'b00010,
        ACTIVE = 5'b00100,
        WRITE  = 5'b01000,
        PREC   = 5'b10000
    } state_t;

    localparam logic [17:0] CMD_NOP  = 18'h1C000;
    localparam logic [17:0] CMD_PALL = 18'h08400;
    localparam logic [1:0]  BA       = 2'b00;

    state_t      state;
    logic        start;
    logic [1:0]  act_cnt;
    logic        act_end;
    logic [1:0]  burst_cnt;
    logic [6:0]  burst_col;
    logic        row_end;
    logic [11:0] row;
    logic        row_end_flag;
    logic        ref_break;
    logic [3:0]  pre_cnt;
    logic        pre_end;
    logic        burst_last;
    logic        brk_hit;

    assign w_req     = (state == WREQ);
    assign src_rd_en = (state == WRITE);
    assign w_dq      = src_rd_data;

    assign write_data_end      = (state == PREC) & row_end_flag & pre_end;
    assign write_ref_break_end = (state == PREC) & ref_break & pre_end;

    assign burst_last = (state == WRITE) && (burst_cnt == 2'd3);
    // A refresh coinciding with the row end is left to the arbiter.
    assign brk_hit    = burst_last && ref_req && !row_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            start        <= 1'b0;
            act_cnt      <= 2'd0;
            act_end      <= 1'b0;
            burst_cnt    <= 2'd0;
            burst_col    <= 7'd0;
            row_end      <= 1'b0;
            row          <= 12'd0;
            row_end_flag <= 1'b0;
            ref_break    <= 1'b0;
            pre_cnt      <= 4'd0;
            pre_end      <= 1'b0;
            w_cmd        <= CMD_NOP;
            w_dq_oe      <= 1'b0;
        end else begin
            start   <= (state == IDLE) &&
                       (src_rd_count >= 11'(START_LEVEL));
            act_cnt <= (state == ACTIVE) ? act_cnt + 2'd1 : 2'd0;
            act_end <= (state == ACTIVE) && (act_cnt == 2'd2);

            burst_cnt <= (state == WRITE) ? burst_cnt + 2'd1 : 2'd0;
            if (row_end)
                burst_col <= 7'd0;
            else if (burst_last)
                burst_col <= burst_col + 7'd1;
            row_end <= (state == WRITE) && (burst_col == 7'd127) &&
                       (burst_cnt == 2'd2);

            if ((state == WRITE) && row_end)
                row <= (row == 12'(ROW_MAX)) ? 12'd0 : row + 12'd1;

            pre_cnt <= ((state == PREC) && (pre_cnt != 4'd8)) ?
                       pre_cnt + 4'd1 : 4'd0;
            pre_end <= (state == PREC) && (pre_cnt == 4'd7);

            if (pre_cnt == 4'd8)
                row_end_flag <= 1'b0;
            else if (row_end)
                row_end_flag <= 1'b1;

            if (pre_cnt == 4'd8)
                ref_break <= 1'b0;
            else if (brk_hit)
                ref_break <= 1'b1;

            w_dq_oe <= (state == WRITE);

            if ((state == ACTIVE) && (act_cnt == 2'd0))
                w_cmd <= {4'b0011, BA, row};
            else if ((state == WRITE) && (burst_cnt == 2'd0))
                w_cmd <= {4'b0100, BA, 3'b000, burst_col, 2'b00};
            else if ((state == PREC) && (pre_cnt == 4'd0))
                w_cmd <= CMD_PALL;
            else
                w_cmd <= CMD_NOP;

            case (state)
                IDLE:   if (start) state <= WREQ;
                WREQ:   if (w_en) state <= ACTIVE;
                ACTIVE: if (act_end) state <= WRITE;
                WRITE: begin
                    if (row_end || (ref_req && burst_cnt == 2'd3))
                        state <= PREC;
                end
                PREC: begin
                    if (pre_end && row_end_flag)
                        state <= IDLE;
                    else if (pre_end && ref_break)
                        state <= WREQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_write.sv
// Scoreboard bench for sdram_write: expected commands and data words are
// queued by the stimulus and popped by a negedge monitor.
module tb_sdram_write;

    localparam int ROW_MAX_TB = 5;
    localparam logic [17:0] NOP  = 18'h1C000;
    localparam logic [17:0] PALL = 18'h08400;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_req;
    logic        w_en;
    logic        ref_req;
    logic        write_ref_break_end;
    logic        write_data_end;
    logic [17:0] w_cmd;
    logic [15:0] w_dq;
    logic        w_dq_oe;
    logic [10:0] src_rd_count;
    logic        src_rd_en;
    logic [15:0] src_rd_data = 16'h0;

    sdram_write #(.ROW_MAX(ROW_MAX_TB), .START_LEVEL(512)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .w_req               (w_req),
        .w_en                (w_en),
        .ref_req             (ref_req),
        .write_ref_break_end (write_ref_break_end),
        .write_data_end      (write_data_end),
        .w_cmd               (w_cmd),
        .w_dq                (w_dq),
        .w_dq_oe             (w_dq_oe),
        .src_rd_count        (src_rd_count),
        .src_rd_en           (src_rd_en),
        .src_rd_data         (src_rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int src_idx = 0;
    int wr_seen = 0;
    int rd_seen = 0;
    int de_seen = 0;
    int be_seen = 0;
    logic [6:0] tgt_col = 7'd0;
    logic [17:0] cmd_q[$];
    logic [15:0] data_q[$];
    logic [17:0] mon_cmd;
    logic [15:0] mon_dq;

    function automatic logic [15:0] word_val(input int i);
        return 16'(i * 37 + 32'h1234);
    endfunction

    function automatic logic [17:0] act_cmd(input logic [11:0] r);
        return {4'b0011, 2'b00, r};
    endfunction

    function automatic logic [17:0] wr_cmd(input logic [6:0] c);
        return {4'b0100, 2'b00, 3'b000, c, 2'b00};
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // source buffer with 1-cycle read latency
    always @(posedge clk) begin
        if (src_rd_en) begin
            src_rd_data <= word_val(src_idx);
            src_idx <= src_idx + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (w_cmd !== NOP) begin
                if (w_cmd[17:14] == 4'b0100) wr_seen++;
                if (cmd_q.size() == 0) begin
                    check("cmd_unexpected", 32'(w_cmd), 32'(NOP));
                end else begin
                    mon_cmd = cmd_q.pop_front();
                    check("cmd", 32'(w_cmd), 32'(mon_cmd));
                end
            end
            if (w_dq_oe) begin
                if (data_q.size() == 0) begin
                    check("dq_unexpected", 32'(w_dq_oe), 32'd0);
                end else begin
                    mon_dq = data_q.pop_front();
                    check("dq", 32'(w_dq), 32'(mon_dq));
                end
            end
            if (src_rd_en) rd_seen++;
            if (write_data_end) de_seen++;
            if (write_ref_break_end) be_seen++;
        end
    end

    function automatic logic probe(input int sel);
        case (sel)
            0: return w_req;
            1: return write_data_end;
            2: return write_ref_break_end;
            3: return w_cmd == wr_cmd(tgt_col);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int max, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = probe(sel);
        end
        check(nm, 32'(hit), 32'd1);
    endtask

    task automatic grant();
        w_en = 1'b1;
        @(posedge clk);
        #1;
        w_en = 1'b0;
    endtask

    task automatic push_row(input logic [11:0] r, input int brk);
        int base;
        base = src_idx;
        cmd_q.push_back(act_cmd(r));
        for (int b = 0; b < 128; b++) begin
            cmd_q.push_back(wr_cmd(7'(b)));
            if (b == brk) begin
                cmd_q.push_back(PALL);
                cmd_q.push_back(act_cmd(r));
            end
        end
        cmd_q.push_back(PALL);
        for (int i = 0; i < 512; i++)
            data_q.push_back(word_val(base + i));
    endtask

    task automatic run_row(input logic [11:0] r, input int brk,
                           input bit coin, input bit chk_t);
        int wr0, rd0, de0, be0, base;
        wr0 = wr_seen;
        rd0 = rd_seen;
        de0 = de_seen;
        be0 = be_seen;
        base = src_idx;
        push_row(r, brk);
        src_rd_count = 11'd512;
        wait_for(0, 20, "w_req_rise");
        src_rd_count = 11'd0;
        grant();
        if (chk_t) begin
            @(posedge clk);
            #1;
            check("act_at_t2", 32'(w_cmd), 32'(act_cmd(r)));
            repeat (4) @(posedge clk);
            #1;
            check("wr_at_t6", 32'(w_cmd), 32'(wr_cmd(7'd0)));
            check("oe_at_t6", 32'(w_dq_oe), 32'd1);
            check("dq_at_t6", 32'(w_dq), 32'(word_val(base)));
        end
        if (brk >= 0) begin
            tgt_col = 7'(brk);
            wait_for(3, 1000, "brk_burst_wr");
            ref_req = 1'b1;
            wait_for(2, 100, "ref_break_end");
            ref_req = 1'b0;
            wait_for(0, 20, "w_req_resume");
            grant();
        end
        if (coin) begin
            tgt_col = 7'd127;
            wait_for(3, 1000, "last_burst_wr");
            ref_req = 1'b1;
        end
        wait_for(1, 1000, "data_end");
        ref_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("wr_count", 32'(wr_seen - wr0), 32'd128);
        check("rd_count", 32'(rd_seen - rd0), 32'd512);
        check("data_end_cnt", 32'(de_seen - de0), 32'd1);
        check("brk_end_cnt", 32'(be_seen - be0), (brk >= 0) ? 32'd1 : 32'd0);
        check("idle_after", 32'({w_req, src_rd_en, w_dq_oe}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        w_en = 1'b0;
        ref_req = 1'b0;
        src_rd_count = 11'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({w_cmd, w_dq_oe, src_rd_en, w_req,
                   write_data_end, write_ref_break_end}),
              32'({NOP, 5'b00000}));
        rst = 1'b0;

        src_rd_count = 11'd511;
        n = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (w_req) n++;
        end
        check("no_req_511", 32'(n), 32'd0);

        src_rd_count = 11'd512;
        @(posedge clk);
        #1;
        check("req_t1", 32'(w_req), 32'd0);
        @(posedge clk);
        #1;
        check("req_t2", 32'(w_req), 32'd1);
        src_rd_count = 11'd0;
        n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (w_cmd !== NOP) n++;
        end
        check("no_act_wo_grant", 32'(n), 32'd0);
        check("req_held", 32'(w_req), 32'd1);

        run_row(12'd0, -1, 1'b0, 1'b1);
        run_row(12'd1, 40, 1'b0, 1'b0);
        run_row(12'd2, -1, 1'b1, 1'b0);
        run_row(12'd3, -1, 1'b0, 1'b0);
        run_row(12'd4, -1, 1'b0, 1'b0);
        run_row(12'd5, -1, 1'b0, 1'b0);
        run_row(12'd0, -1, 1'b0, 1'b0);

        // reset in the middle of a burst on row 1
        push_row(12'd1, -1);
        src_rd_count = 11'd512;
        wait_for(0, 20, "rst_row_req");
        src_rd_count = 11'd0;
        grant();
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_midburst",
              32'({w_cmd, w_dq_oe, src_rd_en, w_req,
                   write_data_end, write_ref_break_end}),
              32'({NOP, 5'b00000}));
        rst = 1'b0;
        cmd_q.delete();
        data_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_rst", 32'(w_req), 32'd0);

        run_row(12'd0, -1, 1'b0, 1'b0);

        check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        check("data_q_drained", 32'(data_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
